// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition event path: FSM encoding, event-word fields, header flag positions.
package acq_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ST_IDLE  = 0;
  localparam int unsigned ST_REQ   = 1;
  localparam int unsigned ST_WAIT  = 2;
  localparam int unsigned ST_SEND  = 3;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned TYPE_LSB = 24;
  localparam int unsigned TYPE_W   = 5;
  localparam int unsigned NUM_W    = 24;

  localparam int unsigned HDR_SEQ_ERR_BIT = 31;
  localparam int unsigned HDR_TIMEOUT_BIT = 30;
  localparam int unsigned HDR_SKIP_BIT    = 29;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 4'b0001,
    REQ       = 4'b0010,
    WAIT_DONE = 4'b0100,
    SEND      = 4'b1000
  } state_e;

  function automatic logic [WORD_W-1:0] make_hdr(input logic seq_err, input logic timeout,
                                                 input logic skipped, input logic [TYPE_W-1:0] trig_type,
                                                 input logic [NUM_W-1:0] trig_num);
    logic [WORD_W-1:0] h;
    h = '0;
    h[NUM_W-1:0]            = trig_num;
    h[TYPE_LSB +: TYPE_W]   = trig_type;
    h[HDR_SKIP_BIT]         = skipped;
    h[HDR_TIMEOUT_BIT]      = timeout;
    h[HDR_SEQ_ERR_BIT]      = seq_err;
    return h;
  endfunction

endpackage

// File: rtl/acq_event_reader_if.sv
// Event-FIFO pop, channel readout and header handshake signals of the event reader.
interface acq_event_reader_if
  import acq_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 5
);
  logic                evt_valid;
  logic                evt_ready;
  logic [WORD_W-1:0]   evt_data;
  logic [NUM_CHAN-1:0] readout_req;
  logic [NUM_CHAN-1:0] readout_dones;
  logic                hdr_valid;
  logic                hdr_ready;
  logic [WORD_W-1:0]   hdr_data;

  modport slave (
    input  evt_valid, evt_data, readout_dones, hdr_ready,
    output evt_ready, readout_req, hdr_valid, hdr_data
  );

  modport master (
    output evt_valid, evt_data, readout_dones, hdr_ready,
    input  evt_ready, readout_req, hdr_valid, hdr_data
  );
endinterface

// File: rtl/sat_counter.sv
// Increment-enable counter that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
endmodule

// File: rtl/acq_event_reader.sv
// Pops acquisition events, checks trigger-number continuity, runs channel readout and emits one header per event.
// Optional readout watchdog enabled by defining ACQ_READER_TIMEOUT_EN.
module acq_event_reader
  import acq_pkg::*;
#(
  parameter int unsigned NUM_CHAN       = 5,
  parameter int unsigned TIMEOUT_CYCLES = 40_000_000,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CHAN-1:0]  chan_en,
  acq_event_reader_if.slave    bus,
  output logic [ERR_CNT_W-1:0] seq_err_cnt,
  output logic [ERR_CNT_W-1:0] timeout_cnt,
  output logic [STATE_W-1:0]   state
);
  state_e              state_q, state_d;
  logic [STATE_W-1:0]  state_bits;
  logic [TYPE_W-1:0]   type_q, type_d, in_type;
  logic [NUM_W-1:0]    num_q, num_d, in_num;
  logic [NUM_CHAN-1:0] en_q, en_d, acc_q, acc_d, req_q, req_d, dones_m;
  logic                seq_err_q, seq_err_d, first_q, first_d;
  logic                hdr_valid_q, hdr_valid_d;
  logic [WORD_W-1:0]   hdr_q, hdr_d;
  logic                mismatch, skipped, seq_inc, to_inc, timed_out;
  logic                unused_evt_hi;

  assign in_num        = bus.evt_data[NUM_W-1:0];
  assign in_type       = bus.evt_data[TYPE_LSB +: TYPE_W];
  assign unused_evt_hi = ^bus.evt_data[WORD_W-1:TYPE_LSB+TYPE_W];
  assign mismatch      = !first_q && (in_num != (num_q + NUM_W'(1)));
  assign skipped       = (in_type == '0) || (chan_en == '0);
  assign dones_m       = bus.readout_dones & en_q;

`ifdef ACQ_READER_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  assign timed_out = (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign timed_out          = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    num_d       = num_q;
    en_d        = en_q;
    acc_d       = acc_q;
    req_d       = '0;
    seq_err_d   = seq_err_q;
    first_d     = first_q;
    hdr_valid_d = hdr_valid_q;
    hdr_d       = hdr_q;
    seq_inc     = 1'b0;
    to_inc      = 1'b0;
`ifdef ACQ_READER_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.evt_valid) begin
          type_d    = in_type;
          num_d     = in_num;
          en_d      = chan_en;
          seq_err_d = mismatch;
          seq_inc   = mismatch;
          first_d   = 1'b0;
          if (skipped) begin
            state_d     = SEND;
            hdr_valid_d = 1'b1;
            hdr_d       = make_hdr(mismatch, 1'b0, 1'b1, in_type, in_num);
          end else begin
            state_d = REQ;
            req_d   = chan_en;
          end
        end
      end
      REQ: begin
        acc_d   = dones_m;
        state_d = WAIT_DONE;
`ifdef ACQ_READER_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      WAIT_DONE: begin
        acc_d = acc_q | dones_m;
`ifdef ACQ_READER_TIMEOUT_EN
        to_cnt_d = to_cnt_q + 32'd1;
`endif
        if ((acc_q | dones_m) == en_q) begin
          state_d     = SEND;
          hdr_valid_d = 1'b1;
          hdr_d       = make_hdr(seq_err_q, 1'b0, 1'b0, type_q, num_q);
        end else if (timed_out) begin
          state_d     = SEND;
          hdr_valid_d = 1'b1;
          to_inc      = 1'b1;
          hdr_d       = make_hdr(seq_err_q, 1'b1, 1'b0, type_q, num_q);
        end
      end
      SEND: begin
        if (bus.hdr_ready) begin
          state_d     = IDLE;
          hdr_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      type_q      <= '0;
      num_q       <= '0;
      en_q        <= '0;
      acc_q       <= '0;
      req_q       <= '0;
      seq_err_q   <= 1'b0;
      first_q     <= 1'b1;
      hdr_valid_q <= 1'b0;
      hdr_q       <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      num_q       <= num_d;
      en_q        <= en_d;
      acc_q       <= acc_d;
      req_q       <= req_d;
      seq_err_q   <= seq_err_d;
      first_q     <= first_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_q       <= hdr_d;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_seq_err_cnt (
    .clk(clk), .reset(reset), .inc_i(seq_inc), .count_o(seq_err_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_timeout_cnt (
    .clk(clk), .reset(reset), .inc_i(to_inc), .count_o(timeout_cnt)
  );

  assign state_bits      = state_q;
  assign state           = state_bits;
  // Pop strobe is held low while reset is asserted even though the state reads IDLE
  assign bus.evt_ready   = state_bits[ST_IDLE] & ~reset;
  assign bus.readout_req = req_q;
  assign bus.hdr_valid   = hdr_valid_q;
  assign bus.hdr_data    = hdr_q;
endmodule

// File: tb/tb_acq_event_reader.sv
// Directed scoreboard bench for acq_event_reader; the watchdog step runs only with ACQ_READER_TIMEOUT_EN.
module tb_acq_event_reader;
  import acq_pkg::*;

  localparam int unsigned NC = 5;
  localparam int unsigned EW = 16;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] chan_en;
  logic [EW-1:0] seq_err_cnt, timeout_cnt;
  logic [3:0]    state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_q[$];
  logic        first_m;
  logic [23:0] prev_m;
  logic [EW-1:0] seq_cnt_m, to_cnt_m;

  acq_event_reader_if #(.NUM_CHAN(NC)) bus ();

  acq_event_reader #(.NUM_CHAN(NC), .TIMEOUT_CYCLES(TO), .ERR_CNT_W(EW)) dut (
    .clk(clk), .reset(reset), .chan_en(chan_en), .bus(bus),
    .seq_err_cnt(seq_err_cnt), .timeout_cnt(timeout_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sb_q.delete();
    first_m   = 1'b1;
    prev_m    = '0;
    seq_cnt_m = '0;
    to_cnt_m  = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'h1);
    chk({tag, "_req"}, 32'(bus.readout_req), 32'h0);
    chk({tag, "_hdr_valid"}, 32'(bus.hdr_valid), 32'h0);
    chk({tag, "_hdr_data"}, bus.hdr_data, 32'h0);
    chk({tag, "_seq_cnt"}, 32'(seq_err_cnt), 32'h0);
    chk({tag, "_to_cnt"}, 32'(timeout_cnt), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.evt_valid = 1'b0;
    bus.readout_dones = '0;
    bus.hdr_ready = 1'b0;
    tick();
    tick();
    model_clear();
    check_idle_outputs("reset");
    chk("reset_evt_ready", 32'(bus.evt_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("post_reset_evt_ready", 32'(bus.evt_ready), 32'h1);
  endtask

  // Drive one event word and push the expected header into the scoreboard
  task automatic send_evt(input logic [4:0] t, input logic [23:0] n, input logic [NC-1:0] en, input logic to);
    logic seq, skip;
    int   w;
    w = 0;
    while (!bus.evt_ready && w < 50) begin
      tick();
      w++;
    end
    chk("evt_ready_wait", 32'(bus.evt_ready), 32'h1);
    seq  = !first_m && (n != prev_m + 24'd1);
    skip = (t == 5'd0) || (en == '0);
    first_m = 1'b0;
    prev_m  = n;
    if (seq && seq_cnt_m != '1) seq_cnt_m++;
    if (to && to_cnt_m != '1) to_cnt_m++;
    sb_q.push_back({seq, to, skip, t, n});
    chan_en       = en;
    bus.evt_data  = {3'd0, t, n};
    bus.evt_valid = 1'b1;
    tick();
    bus.evt_valid = 1'b0;
  endtask

  task automatic recv_hdr(input string tag, input int bound);
    int w;
    logic [31:0] exp;
    w = 0;
    while (!bus.hdr_valid && w < bound) begin
      tick();
      w++;
    end
    chk({tag, "_hdr_valid"}, 32'(bus.hdr_valid), 32'h1);
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'h1);
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      chk({tag, "_hdr_data"}, bus.hdr_data, exp);
    end
    bus.hdr_ready = 1'b1;
    tick();
    bus.hdr_ready = 1'b0;
    chk({tag, "_back_idle"}, 32'(state), 32'h1);
    chk({tag, "_hdr_dropped"}, 32'(bus.hdr_valid), 32'h0);
  endtask

  task automatic run_simple(input string tag, input logic [4:0] t, input logic [23:0] n, input logic [NC-1:0] en);
    send_evt(t, n, en, 1'b0);
    if (t != 5'd0 && en != '0) begin
      bus.readout_dones = en;
      tick();
      bus.readout_dones = '0;
    end
    recv_hdr(tag, 20);
  endtask

  initial begin
    chan_en = '0;
    bus.evt_data = '0;
    model_clear();

    // 1: full readout with staggered dones
    do_reset();
    send_evt(5'd1, 24'h000005, 5'h1F, 1'b0);
    chk("t1_req", 32'(bus.readout_req), 32'h1F);
    chk("t1_state_req", 32'(state), 32'h2);
    bus.readout_dones = 5'h01;
    tick();
    chk("t1_req_single", 32'(bus.readout_req), 32'h0);
    chk("t1_state_wait", 32'(state), 32'h4);
    bus.readout_dones = 5'h06;
    tick();
    chk("t1_still_wait", 32'(state), 32'h4);
    bus.readout_dones = 5'h18;
    tick();
    bus.readout_dones = '0;
    chk("t1_literal_hdr", bus.hdr_data, 32'h01000005);
    recv_hdr("t1", 5);

    // 2: sequence gap, then 24-bit wrap
    do_reset();
    run_simple("t2a", 5'd1, 24'd7, 5'h01);
    run_simple("t2b", 5'd1, 24'd9, 5'h01);
    chk("t2_seq_cnt_literal", 32'(seq_err_cnt), 32'd1);
    run_simple("t2c", 5'd2, 24'hFFFFFF, 5'h01);
    run_simple("t2d", 5'd2, 24'h000000, 5'h01);
    chk("t2_seq_cnt_after_wrap", 32'(seq_err_cnt), 32'(seq_cnt_m));

    // 3: skipped event with downstream backpressure
    send_evt(5'd0, 24'd1, 5'h1F, 1'b0);
    chk("t3_no_req", 32'(bus.readout_req), 32'h0);
    chk("t3_state_send", 32'(state), 32'h8);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hdr_stable", bus.hdr_data, sb_q[0]);
      chk("t3_evt_ready_low", 32'(bus.evt_ready), 32'h0);
      chk("t3_req_low", 32'(bus.readout_req), 32'h0);
      tick();
    end
    recv_hdr("t3", 2);

    // 4: dones on unenabled channels, chan_en change mid-WAIT
    send_evt(5'd1, 24'd2, 5'h03, 1'b0);
    bus.readout_dones = 5'h1C;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) chan_en = 5'h1C;
      chk("t4_wait_hold", 32'(state), 32'h4);
      tick();
    end
    bus.readout_dones = 5'h03;
    tick();
    bus.readout_dones = '0;
    chk("t4_state_send", 32'(state), 32'h8);
    recv_hdr("t4", 2);

    // Empty channel mask is a skipped event
    send_evt(5'd3, 24'd3, 5'h00, 1'b0);
    chk("skip_en0_req", 32'(bus.readout_req), 32'h0);
    recv_hdr("skip_en0", 3);

`ifdef ACQ_READER_TIMEOUT_EN
    // 5: watchdog expiry
    send_evt(5'd2, 24'd4, 5'h01, 1'b1);
    chk("t5_state_req", 32'(state), 32'h2);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("t5_wait", 32'(state), 32'h4);
      tick();
    end
    chk("t5_state_send", 32'(state), 32'h8);
    recv_hdr("t5", 1);
    chk("t5_to_cnt", 32'(timeout_cnt), 32'd1);
    prev_m = 24'd4;
`else
    run_simple("t5_alt", 5'd2, 24'd4, 5'h01);
    chk("t5_to_cnt_tied", 32'(timeout_cnt), 32'd0);
`endif

    // 6: reset during WAIT drops the event; next event is first
    send_evt(5'd1, 24'd5, 5'h1F, 1'b0);
    tick();
    chk("t6_in_wait", 32'(state), 32'h4);
    chk("t6_seq_cnt_before", 32'(seq_err_cnt), 32'(seq_cnt_m));
    reset = 1'b1;
    #1;
    check_idle_outputs("t6_rst");
    chk("t6_rst_evt_ready", 32'(bus.evt_ready), 32'h0);
    model_clear();
    tick();
    reset = 1'b0;
    #1;
    run_simple("t6_first", 5'd1, 24'h000200, 5'h1F);
    chk("t6_seq_cnt_after", 32'(seq_err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
